// File: rtl/cp0_coprocessor.sv
// MIPS-style coprocessor-0 register file: mfc0/mtc0 access plus EPC/Cause capture on exception entry.
// Optional macro CP0_COUNT_EN makes register 9 a free-running Count register.
module cp0_coprocessor #(
    parameter int          EPC_IDX    = 14,
    parameter int          CAUSE_IDX  = 13,
    parameter int          STATUS_IDX = 12,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  c0_rd_addr,
    input  logic [4:0]  c0_wr_addr,
    input  logic [31:0] c0_w_data,
    input  logic [31:0] pc_i,
    input  logic        InTcause,
    input  logic        c0_reg_we,
    input  logic        WriteEPC,
    input  logic        WriteCause,
    output logic [31:0] c0_r_data,
    output logic [31:0] epc_o
);

    localparam logic [4:0] EPC_A    = EPC_IDX[4:0];
    localparam logic [4:0] CAUSE_A  = CAUSE_IDX[4:0];
    localparam logic [4:0] STATUS_A = STATUS_IDX[4:0];
    localparam logic [4:0] COUNT_A  = 5'd9;

    logic [31:0] regs_r [32];
    logic [31:0] next_s [32];

    // Cause word for exception entry: ExcCode 0 for interrupt, 8 for syscall.
    function automatic logic [31:0] cause_word(input logic intr);
        logic [4:0] exc_code;
        if (intr) begin
            exc_code = 5'd0;
        end else begin
            exc_code = 5'd8;
        end
        return {25'd0, exc_code, 2'b00};
    endfunction

    // Next-state of the register file; hardware captures are applied last so they override mtc0.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            next_s[i] = regs_r[i];
        end
`ifdef CP0_COUNT_EN
        next_s[COUNT_A] = regs_r[COUNT_A] + 32'd1;
`endif
        if (c0_reg_we) begin
            next_s[c0_wr_addr] = c0_w_data;
        end else begin
            next_s[c0_wr_addr] = next_s[c0_wr_addr];
        end
        if (WriteEPC) begin
            next_s[EPC_A] = pc_i;
        end else begin
            next_s[EPC_A] = next_s[EPC_A];
        end
        if (WriteCause) begin
            next_s[CAUSE_A] = cause_word(InTcause);
        end else begin
            next_s[CAUSE_A] = next_s[CAUSE_A];
        end
    end

    // Register storage with asynchronous reset; Status resets to its configured value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                if (i[4:0] == STATUS_A) begin
                    regs_r[i] <= STATUS_RST;
                end else begin
                    regs_r[i] <= 32'h0000_0000;
                end
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= next_s[i];
            end
        end
    end

    // Reads are combinational with no bypass of same-cycle writes.
    always_comb begin
        c0_r_data = regs_r[c0_rd_addr];
        epc_o     = regs_r[EPC_A];
    end

    // COUNT_A is referenced only when the Count feature is built in.
    logic unused_s;
    always_comb begin
        unused_s = &{1'b0, COUNT_A};
    end

endmodule

// File: tb/tb_cp0_coprocessor.sv
// Scoreboard bench for cp0_coprocessor; honours CP0_COUNT_EN when defined.
`timescale 1ns/1ps
module tb_cp0_coprocessor;

    localparam logic [31:0] ST_RST = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  c0_rd_addr, c0_wr_addr;
    logic [31:0] c0_w_data, pc_i;
    logic        InTcause, c0_reg_we, WriteEPC, WriteCause;
    logic [31:0] c0_r_data, epc_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [4:0]  addr;
        logic [31:0] exp;
        bit          is_epc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [32];

    cp0_coprocessor #(.STATUS_RST(ST_RST)) dut (
        .clk(clk), .rst(rst),
        .c0_rd_addr(c0_rd_addr), .c0_wr_addr(c0_wr_addr), .c0_w_data(c0_w_data),
        .pc_i(pc_i), .InTcause(InTcause), .c0_reg_we(c0_reg_we),
        .WriteEPC(WriteEPC), .WriteCause(WriteCause),
        .c0_r_data(c0_r_data), .epc_o(epc_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = (i == 12) ? ST_RST : 32'h0;
    endtask

    task automatic push_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.addr = a; x.exp = e; x.is_epc = 1'b0;
        sb_q.push_back(x);
    endtask

    task automatic push_epc(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.addr = 5'd0; x.exp = e; x.is_epc = 1'b1;
        sb_q.push_back(x);
    endtask

    // Pops every queued expectation and compares against the DUT outputs.
    task automatic drain();
        exp_t x;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            if (x.is_epc) begin
                check_val(x.tag, epc_o, x.exp);
            end else begin
                c0_rd_addr = x.addr;
                #1;
                check_val(x.tag, c0_r_data, x.exp);
            end
        end
    endtask

    task automatic idle();
        c0_reg_we = 1'b0; WriteEPC = 1'b0; WriteCause = 1'b0;
        InTcause = 1'b0; c0_wr_addr = 5'd0; c0_w_data = 32'h0; pc_i = 32'h0;
    endtask

    // Applies the current inputs to the model, clocks one edge, then clears inputs.
    task automatic step();
        logic [31:0] nxt [32];
        for (int i = 0; i < 32; i++) nxt[i] = mdl[i];
`ifdef CP0_COUNT_EN
        nxt[9] = mdl[9] + 32'd1;
`endif
        if (c0_reg_we) nxt[c0_wr_addr] = c0_w_data;
        if (WriteEPC) nxt[14] = pc_i;
        if (WriteCause) nxt[13] = InTcause ? 32'h0000_0000 : 32'h0000_0020;
        @(posedge clk);
        for (int i = 0; i < 32; i++) mdl[i] = nxt[i];
        #1;
        idle();
    endtask

    initial begin
        logic [4:0] a;
        idle();
        c0_rd_addr = 5'd0;
        rst = 1'b1;
        model_reset();
        #2;
        push_rd("rst_status", 5'd12, ST_RST);
        push_rd("rst_r0", 5'd0, 32'h0);
        push_epc("rst_epc", 32'h0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // mtc0 with same-cycle read of the old value
        c0_reg_we = 1'b1; c0_wr_addr = 5'd5; c0_w_data = 32'hDEAD_BEEF;
        c0_rd_addr = 5'd5;
        #1;
        check_val("no_bypass", c0_r_data, 32'h0);
        step();
        push_rd("mtc0_r5", 5'd5, 32'hDEAD_BEEF);
        drain();

        // syscall entry
        WriteEPC = 1'b1; WriteCause = 1'b1; InTcause = 1'b0; pc_i = 32'h0000_0040;
        step();
        push_epc("sys_epc", 32'h0000_0040);
        push_rd("sys_cause", 5'd13, 32'h0000_0020);
        drain();

        // interrupt entry
        WriteEPC = 1'b1; WriteCause = 1'b1; InTcause = 1'b1; pc_i = 32'h0000_1234;
        step();
        push_epc("int_epc", 32'h0000_1234);
        push_rd("int_cause", 5'd13, 32'h0000_0000);
        drain();

        // mtc0 to EPC collides with WriteEPC
        c0_reg_we = 1'b1; c0_wr_addr = 5'd14; c0_w_data = 32'h1111_1111;
        WriteEPC = 1'b1; pc_i = 32'h2222_2222;
        step();
        push_epc("conf_epc", 32'h2222_2222);
        drain();

        // mtc0 to Cause collides with WriteCause
        c0_reg_we = 1'b1; c0_wr_addr = 5'd13; c0_w_data = 32'hFFFF_FFFF;
        WriteCause = 1'b1; InTcause = 1'b0;
        step();
        push_rd("conf_cause", 5'd13, 32'h0000_0020);
        drain();

        // mtc0 elsewhere proceeds alongside a capture
        c0_reg_we = 1'b1; c0_wr_addr = 5'd3; c0_w_data = 32'h0BAD_F00D;
        WriteEPC = 1'b1; pc_i = 32'h0000_8000;
        step();
        push_rd("par_r3", 5'd3, 32'h0BAD_F00D);
        push_epc("par_epc", 32'h0000_8000);
        drain();

        // plain mtc0 to Status, EPC and Cause
        c0_reg_we = 1'b1; c0_wr_addr = 5'd12; c0_w_data = 32'h0000_FF01;
        step();
        c0_reg_we = 1'b1; c0_wr_addr = 5'd14; c0_w_data = 32'hCAFE_0004;
        step();
        c0_reg_we = 1'b1; c0_wr_addr = 5'd13; c0_w_data = 32'h0000_007C;
        step();
        push_rd("mtc0_status", 5'd12, 32'h0000_FF01);
        push_epc("mtc0_epc", 32'hCAFE_0004);
        push_rd("mtc0_cause", 5'd13, 32'h0000_007C);
        drain();

        // random traffic against the model
        for (int n = 0; n < 24; n++) begin
            c0_reg_we = 1'($urandom_range(1, 0));
            c0_wr_addr = 5'($urandom_range(31, 0));
            c0_w_data = $urandom();
            WriteEPC = ($urandom_range(3, 0) == 0);
            WriteCause = ($urandom_range(3, 0) == 0);
            InTcause = 1'($urandom_range(1, 0));
            pc_i = $urandom();
            step();
            a = 5'($urandom_range(31, 0));
            push_rd("rand_rd", a, mdl[a]);
            push_epc("rand_epc", mdl[14]);
            drain();
        end

`ifdef CP0_COUNT_EN
        c0_reg_we = 1'b1; c0_wr_addr = 5'd9; c0_w_data = 32'h0;
        step();
        for (int n = 0; n < 4; n++) begin
            push_rd("count_inc", 5'd9, 32'(n));
            drain();
            step();
        end
        c0_reg_we = 1'b1; c0_wr_addr = 5'd9; c0_w_data = 32'hFFFF_FFFF;
        step();
        push_rd("count_load", 5'd9, 32'hFFFF_FFFF);
        drain();
        step();
        push_rd("count_wrap", 5'd9, 32'h0);
        drain();
`else
        c0_reg_we = 1'b1; c0_wr_addr = 5'd9; c0_w_data = 32'h1357_9BDF;
        step();
        step();
        step();
        push_rd("r9_hold", 5'd9, 32'h1357_9BDF);
        drain();
`endif

        // asynchronous reset mid-cycle with a write pending
        c0_reg_we = 1'b1; c0_wr_addr = 5'd7; c0_w_data = 32'h7777_7777;
        WriteEPC = 1'b1; pc_i = 32'h4444_4444;
        #2;
        rst = 1'b1;
        model_reset();
        #0.5;
        check_val("arst_epc", epc_o, 32'h0);
        idle();
        for (int i = 0; i < 32; i++) begin
            push_rd("arst_rd", 5'(i), (i == 12) ? ST_RST : 32'h0);
        end
        drain();
        @(negedge clk);
        rst = 1'b0;
        step();
        push_rd("post_rst_r7", 5'd7, mdl[7]);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_coprocessor.md
Name: cp0_coprocessor

Overview:
- MIPS-style coprocessor-0 register block for the multi-cycle CPU datapath.
- Holds 32 × 32-bit system-control registers.
- Serves mfc0 reads and mtc0 writes.
- Captures EPC and Cause on exception/interrupt entry, and presents EPC to the PC mux for eret.

Parameters:
- EPC_IDX, 14, register index holding the exception PC.
- CAUSE_IDX, 13, register index holding the Cause word.
- STATUS_IDX, 12, register index holding Status.
- STATUS_RST, 32'h0000_0000, reset value of Status.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- c0_rd_addr  input  5  mfc0 read index (rd field of instruction).
- c0_wr_addr  input  5  mtc0 write index.
- c0_w_data  input  32  mtc0 write data (GPR rt value).
- pc_i  input  32  PC value captured into EPC when WriteEPC=1.
- InTcause  input  1  cause select: 0 = syscall, 1 = external interrupt.
- c0_reg_we  input  1  mtc0 write enable.
- WriteEPC  input  1  load EPC from pc_i.
- WriteCause  input  1  load Cause from InTcause.
- c0_r_data  output  32  mfc0 read data.
- epc_o  output  32  current EPC contents, for eret.

Behaviour:
- Storage: 32 registers, 32 bits each, all readable.
- Reset:
  - While rst=1, every register is 0, except Status = STATUS_RST.
  - Outputs follow: c0_r_data=0 for any index except STATUS_IDX; epc_o=0.
  - Reset is asynchronous; it overrides any write pending in the same cycle.
- Read:
  - c0_r_data = reg[c0_rd_addr], combinational.
  - No write-through bypass: a read of an index written this cycle returns the old value until after the edge.
- EPC output: epc_o = reg[EPC_IDX], combinational. Updates one clk after a write to EPC.
- mtc0: if c0_reg_we=1, reg[c0_wr_addr] <= c0_w_data on the rising edge. All 32 indices are writable, including EPC, Cause and Status.
- EPC capture: if WriteEPC=1, reg[EPC_IDX] <= pc_i.
- Cause capture: if WriteCause=1, reg[CAUSE_IDX] <= {25'b0, ExcCode[4:0], 2'b00}.
  - ExcCode = 5'd0 when InTcause=1 (interrupt).
  - ExcCode = 5'd8 when InTcause=0 (syscall).
  - Resulting Cause value: 32'h0000_0000 for interrupt, 32'h0000_0020 for syscall.
- Simultaneous events:
  - WriteEPC and WriteCause may assert in the same cycle; both registers update.
  - If c0_reg_we targets EPC_IDX while WriteEPC=1, pc_i wins.
  - If c0_reg_we targets CAUSE_IDX while WriteCause=1, the hardware cause value wins.
  - An mtc0 to any other index proceeds in parallel.
- Latency: single-cycle writes, zero-cycle reads. No handshake; the block never stalls.

Optional Feature:
- Macro CP0_COUNT_EN.
- When defined: register 9 (Count) increments by 1 every clk edge, wrapping 32'hFFFF_FFFF→0.
  - An mtc0 to index 9 loads c0_w_data instead of incrementing that cycle.
  - Reset clears it to 0.
- When undefined: index 9 is an ordinary read/write register with no auto-increment.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after prior writes → c0_r_data=0 for indices 0..31 (except Status=STATUS_RST) and epc_o=0, immediately, without waiting for a clk edge.
- mtc0/mfc0: write 32'hDEAD_BEEF to index 5 with c0_reg_we=1.
  - Same cycle: reading index 5 returns the old value 0.
  - After the edge: reading index 5 returns 32'hDEAD_BEEF.
- Syscall entry: WriteEPC=1, WriteCause=1, InTcause=0, pc_i=32'h0000_0040 → next cycle epc_o=32'h0000_0040 and Cause (rd=13) = 32'h0000_0020.
- Interrupt entry: same stimulus with InTcause=1, pc_i=32'h0000_1234 → epc_o=32'h0000_1234, Cause=32'h0.
- Conflict: c0_reg_we=1, c0_wr_addr=14, c0_w_data=32'h1111_1111, with WriteEPC=1, pc_i=32'h2222_2222 → epc_o=32'h2222_2222.
- CP0_COUNT_EN: defined, no writes → index 9 reads 0,1,2… per cycle. mtc0 of 32'hFFFF_FFFF → reads 0 two cycles later.
